// File: rtl/dmem_unit.sv
// dmem_unit: word-organised data memory with RISC-V byte/half/word loads and stores.
// Optional feature macro DMEM_MMIO_LED_EN maps the word at LED_ADDR onto the led register.
module dmem_unit #(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] LED_ADDR = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] led
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      r_state;
  state_t      w_nextState;

  // Contents survive reset; only the power-up value is defined.
  logic [31:0] r_mem [DEPTH] = '{default: '0};

  logic [31:0] r_rdata;
  logic        r_err;
  logic [AW-1:0] r_idx;
  logic [1:0]  r_off;
  logic [2:0]  r_funct3;

  logic          w_accept;
  logic [AW-1:0] w_idx;
  logic          w_err;
  logic          w_storeOk;
  logic [3:0]    w_be;
  logic [31:0]   w_wdataRep;
  logic [3:0]    w_memWe;
  logic [31:0]   w_rword;
  logic [15:0]   w_lane;
  logic [31:0]   w_loadData;

  assign w_accept  = req_valid && (r_state == IDLE);
  assign w_idx     = req_addr[AW+1:2];
  assign w_storeOk = w_accept && rst && req_we && !w_err;

  always_comb begin
    w_err = 1'b0;
    case (req_funct3)
      3'd0:    w_err = 1'b0;
      3'd1:    w_err = req_addr[0];
      3'd2:    w_err = |req_addr[1:0];
      3'd4:    w_err = req_we;
      3'd5:    w_err = req_we | req_addr[0];
      default: w_err = 1'b1;
    endcase
  end

  // Narrow store data is replicated across lanes so each enabled byte sees its own copy.
  always_comb begin
    w_be       = 4'b1111;
    w_wdataRep = req_wdata;
    case (req_funct3[1:0])
      2'd0: begin
        w_be       = 4'b0001 << req_addr[1:0];
        w_wdataRep = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        w_be       = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdataRep = {2{req_wdata[15:0]}};
      end
      default: begin
        w_be       = 4'b1111;
        w_wdataRep = req_wdata;
      end
    endcase
  end

`ifdef DMEM_MMIO_LED_EN
  logic       r_ledHit;
  logic [31:0] r_led;
  logic       w_ledHit;
  logic [3:0] w_ledWe;

  assign w_ledHit = (req_addr[31:2] == LED_ADDR[31:2]);
  assign w_memWe  = (w_storeOk && !w_ledHit) ? w_be : 4'b0000;
  assign w_ledWe  = (w_storeOk && w_ledHit) ? w_be : 4'b0000;
  assign w_rword  = r_ledHit ? r_led : r_mem[r_idx];
  assign led      = r_led;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_led    <= '0;
      r_ledHit <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ledHit <= w_ledHit;
      end
      for (int b = 0; b < 4; b++) begin
        if (w_ledWe[b]) begin
          r_led[8*b +: 8] <= w_wdataRep[8*b +: 8];
        end
      end
    end
  end
`else
  logic w_unused;

  assign w_unused = ^{req_addr[31:AW+2], LED_ADDR};
  assign w_memWe  = w_storeOk ? w_be : 4'b0000;
  assign w_rword  = r_mem[r_idx];
  assign led      = '0;
`endif

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_memWe[b]) begin
        r_mem[w_idx][8*b +: 8] <= w_wdataRep[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_lane     = 16'(w_rword >> {r_off, 3'b000});
    w_loadData = w_rword;
    case (r_funct3)
      3'd0:    w_loadData = {{24{w_lane[7]}}, w_lane[7:0]};
      3'd4:    w_loadData = {24'd0, w_lane[7:0]};
      3'd1:    w_loadData = {{16{w_lane[15]}}, w_lane};
      3'd5:    w_loadData = {16'd0, w_lane};
      default: w_loadData = w_rword;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          w_nextState = (req_we || w_err) ? RESP : ACCESS;
        end
      end
      ACCESS: w_nextState = RESP;
      RESP: begin
        resp_valid  = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Response data/error change only on entry to RESP and otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_idx    <= '0;
      r_off    <= '0;
      r_funct3 <= '0;
    end else begin
      if (w_accept) begin
        r_idx    <= w_idx;
        r_off    <= req_addr[1:0];
        r_funct3 <= req_funct3;
        if (req_we || w_err) begin
          r_rdata <= '0;
          r_err   <= w_err;
        end
      end
      if (r_state == ACCESS) begin
        r_rdata <= w_loadData;
        r_err   <= 1'b0;
      end
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
